// File: rtl/demo_io_ctrl.sv
// Front-panel demo controller: synchronises and debounces the board inputs, then issues step pulses or selects the display channel.
// Step pulse / channel change land DEB_CYCLES+3 edges after the raw press; no backpressure. Optional auto-scan under DEMO_AUTOSCAN_EN.
module demo_io_ctrl #(
  parameter  int DATA_W      = 16,
  parameter  int NUM_CH      = 4,
  parameter  int DEB_CYCLES  = 16,
  parameter  int SCAN_CYCLES = 1024,
  localparam int IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     button,
  input  logic                     mode,
  input  logic                     RAMSel,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic                     step_pulse,
  output logic                     ram_sel,
  output logic [IDX_W-1:0]         ch_idx,
  output logic [DATA_W-1:0]        out
);

  localparam int                CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  if (NUM_CH < 2 || DEB_CYCLES < 2 || SCAN_CYCLES < 1) begin : g_param_chk
    $error("demo_io_ctrl: NUM_CH and DEB_CYCLES must be >= 2, SCAN_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE_LO      = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD_HI      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  logic btn_s1, btn_s2, mode_s1, mode_s2, ram_s1;
  deb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             evt_step, evt_view;
  logic             advance;
  logic [IDX_W-1:0] idx_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
      ram_s1  <= 1'b0;
      ram_sel <= 1'b0;
    end else begin
      btn_s1  <= button;
      btn_s2  <= btn_s1;
      mode_s1 <= mode;
      mode_s2 <= mode_s1;
      ram_s1  <= RAMSel;
      ram_sel <= ram_s1;
    end
  end

  // Press event is registered together with the mode seen on the same edge,
  // so a mode flip mid-debounce cannot split one press into both actions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE_LO;
      cnt      <= '0;
      evt_step <= 1'b0;
      evt_view <= 1'b0;
    end else begin
      evt_step <= 1'b0;
      evt_view <= 1'b0;
      case (state)
        IDLE_LO: begin
          if (btn_s2) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s2) begin
            state <= IDLE_LO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state    <= HELD_HI;
            cnt      <= '0;
            evt_step <= ~mode_s2;
            evt_view <= mode_s2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD_HI: begin
          if (!btn_s2) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s2) begin
            state <= HELD_HI;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_LO;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE_LO;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef DEMO_AUTOSCAN_EN
  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  logic [SCAN_W-1:0] scan_cnt;
  logic              scan_exp;

  assign scan_exp = mode_s2 && (scan_cnt == SCAN_W'(SCAN_CYCLES - 1));
  assign advance  = evt_view | scan_exp;

  // A press restarts the dwell so the operator gets a full period on the new channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
    end else if (!mode_s2 || evt_view || scan_exp) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end
`else
  assign advance = evt_view;
`endif

  assign idx_nxt = (ch_idx == IDX_W'(NUM_CH - 1)) ? '0 : ch_idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_pulse <= 1'b0;
      ch_idx     <= '0;
      out        <= '0;
    end else begin
      step_pulse <= evt_step;
      if (advance) begin
        ch_idx <= idx_nxt;
      end
      if (ch_valid[ch_idx]) begin
        out <= ch_data[ch_idx*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_demo_io_ctrl.sv
// Scoreboard bench for demo_io_ctrl: stimulus pushes expected output events (cycle, value),
// a negedge monitor pops them whenever step_pulse fires or ch_idx/out/ram_sel change.
module tb_demo_io_ctrl;
  localparam int DATA_W = 16;
  localparam int NUM_CH = 4;
  localparam int DEB    = 4;
  localparam int SCAN   = 8;
  localparam int LAT    = DEB + 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     button = 1'b0;
  logic                     mode = 1'b0;
  logic                     RAMSel = 1'b0;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid = '0;
  logic                     step_pulse;
  logic                     ram_sel;
  logic [1:0]               ch_idx;
  logic [DATA_W-1:0]        out;

  typedef struct {
    int c;
    int v;
  } ev_t;

  ev_t  exp_idx[$];
  ev_t  exp_out[$];
  ev_t  exp_ram[$];
  int   exp_step[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   idx_m = 0;
  int   out_m = 0;
  logic [NUM_CH-1:0] valid_m = '0;
  logic [1:0]        prev_idx;
  logic [DATA_W-1:0] prev_out;
  logic              prev_ram;
  ev_t               mon_e;

  demo_io_ctrl #(
    .DATA_W     (DATA_W),
    .NUM_CH     (NUM_CH),
    .DEB_CYCLES (DEB),
    .SCAN_CYCLES(SCAN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .button    (button),
    .mode      (mode),
    .RAMSel    (RAMSel),
    .ch_data   (ch_data),
    .ch_valid  (ch_valid),
    .step_pulse(step_pulse),
    .ram_sel   (ram_sel),
    .ch_idx    (ch_idx),
    .out       (out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int dat(input int i);
    return 'hA000 + i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of one view-mode press landing at edge k+LAT.
  task automatic push_view(input int k);
    idx_m = (idx_m + 1) % NUM_CH;
    exp_idx.push_back('{k + LAT, idx_m});
    if (valid_m[idx_m] && out_m != dat(idx_m)) begin
      exp_out.push_back('{k + LAT + 1, dat(idx_m)});
      out_m = dat(idx_m);
    end
  endtask

  task automatic press(input int hold);
    int k;
    button = 1'b1;
    k = cyc;
    if (mode == 1'b0) exp_step.push_back(k + LAT);
    else push_view(k);
    repeat (hold) tick();
    button = 1'b0;
    repeat (12) tick();
  endtask

  task automatic set_mode(input logic m);
    mode = m;
    repeat (4) tick();
  endtask

  task automatic do_reset(output int r);
    rst = 1'b0;
    #1;
    chk("arst_step", step_pulse, 0);
    chk("arst_ram", ram_sel, 0);
    chk("arst_idx", ch_idx, 0);
    chk("arst_out", out, 0);
    repeat (2) tick();
    rst = 1'b1;
    r = cyc;
    idx_m = 0;
    out_m = dat(0);
    exp_out.push_back('{r + 1, dat(0)});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_idx = ch_idx;
      prev_out = out;
      prev_ram = ram_sel;
    end else begin
      if (step_pulse) begin
        chk("step_expected", exp_step.size() > 0, 1);
        if (exp_step.size() > 0) chk("step_cycle", cyc, exp_step.pop_front());
      end
      if (ch_idx !== prev_idx) begin
        chk("idx_expected", exp_idx.size() > 0, 1);
        if (exp_idx.size() > 0) begin
          mon_e = exp_idx.pop_front();
          chk("idx_cycle", cyc, mon_e.c);
          chk("idx_value", ch_idx, mon_e.v);
        end
        prev_idx = ch_idx;
      end
      if (out !== prev_out) begin
        chk("out_expected", exp_out.size() > 0, 1);
        if (exp_out.size() > 0) begin
          mon_e = exp_out.pop_front();
          chk("out_cycle", cyc, mon_e.c);
          chk("out_value", out, mon_e.v);
        end
        prev_out = out;
      end
      if (ram_sel !== prev_ram) begin
        chk("ram_expected", exp_ram.size() > 0, 1);
        if (exp_ram.size() > 0) begin
          mon_e = exp_ram.pop_front();
          chk("ram_cycle", cyc, mon_e.c);
          chk("ram_value", ram_sel, mon_e.v);
        end
        prev_ram = ram_sel;
      end
    end
  end

  initial begin
    int k;
    int r;
    for (int i = 0; i < NUM_CH; i++) ch_data[i*DATA_W +: DATA_W] = DATA_W'(dat(i));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_step", step_pulse, 0);
    chk("rst_ram", ram_sel, 0);
    chk("rst_idx", ch_idx, 0);
    chk("rst_out", out, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) tick();

    ch_valid = '1;
    valid_m  = '1;
    exp_out.push_back('{cyc + 1, dat(0)});
    out_m = dat(0);
    repeat (2) tick();

    RAMSel = 1'b1;
    exp_ram.push_back('{cyc + 2, 1});
    repeat (5) tick();
    RAMSel = 1'b0;
    exp_ram.push_back('{cyc + 2, 0});
    repeat (5) tick();

    // Held press in step mode: a single pulse, no repeats.
    press(20);

    button = 1'b1; tick();
    button = 1'b0; tick();
    button = 1'b1; tick();
    button = 1'b0; repeat (12) tick();
    chk("bounce_state", 32'(dut.state), 0);
    press(10);

`ifdef DEMO_AUTOSCAN_EN
    mode = 1'b1;
    k = cyc;
    for (int j = 0; j < 7; j++) begin
      idx_m = (idx_m + 1) % NUM_CH;
      exp_idx.push_back('{k + 10 + SCAN*j, idx_m});
      exp_out.push_back('{k + 11 + SCAN*j, dat(idx_m)});
      out_m = dat(idx_m);
    end
    // This press lands on the same edge as the k+50 expiry.
    while (cyc < k + 43) tick();
    button = 1'b1;
    repeat (12) tick();
    button = 1'b0;
    while (cyc < k + 60) tick();
    mode = 1'b0;
    repeat (20) tick();
`else
    set_mode(1'b1);
    repeat (5) press(10);
    chk("view_idx", ch_idx, idx_m);

    ch_valid = 4'b1011;
    valid_m  = 4'b1011;
    press(10);
    chk("hold_out", out, dat(1));
    ch_valid = '1;
    valid_m  = '1;
    exp_out.push_back('{cyc + 1, dat(2)});
    out_m = dat(2);
    repeat (3) tick();
    set_mode(1'b0);
`endif

    button = 1'b1;
    repeat (4) tick();
    chk("pw_state", 32'(dut.state), 1);
    do_reset(r);
    exp_step.push_back(r + LAT);
    repeat (LAT + 3) tick();
    button = 1'b0;
    repeat (12) tick();

    button = 1'b1;
    k = cyc;
    exp_step.push_back(k + LAT);
    while (cyc < k + LAT) tick();
    @(negedge clk);
    #1;
    do_reset(r);
    exp_step.push_back(r + LAT);
    repeat (LAT + 3) tick();
    button = 1'b0;
    repeat (20) tick();

    chk("left_step", exp_step.size(), 0);
    chk("left_idx", exp_idx.size(), 0);
    chk("left_out", exp_out.size(), 0);
    chk("left_ram", exp_ram.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
